instruction_fetch_unit: RTL and testbench

//  Requester side of the instruction memory: owns the PC and drives the word address.
//  The memory returns the registered data word one cycle after the address.
//  A 2-entry buffer absorbs in-flight words, giving a valid/ready stream of instruction+PC to decode.

---
 rtl/ifu_pkg.sv | 29 ++
 rtl/ifu_skid_fifo.sv | 74 +++++++
 rtl/instruction_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ----------------------------------------------------------------------------
// ifu_pkg
// Shared types and constants for the instruction fetch unit.
//   ifu_state_t   : fetch FSM state (BOOT, RUN, HALTED)
//   fetch_entry_t : one fetched word plus the word address it came from
//   NOP_WORD      : value presented on dec_inst while nothing has been fetched
// ----------------------------------------------------------------------------
package ifu_pkg;

    localparam int IFU_ADDR_W = 6;
    localparam int IFU_DATA_W = 32;

    localparam logic [IFU_DATA_W-1:0] NOP_WORD          = 32'h0007_8000;
    localparam logic [IFU_DATA_W-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } ifu_state_t;

    typedef struct packed {
        logic [IFU_DATA_W-1:0] inst;
        logic [IFU_ADDR_W-1:0] pc;
    } fetch_entry_t;

    localparam fetch_entry_t ENTRY_RESET = '{inst: NOP_WORD, pc: '0};

endpackage

// File: rtl/ifu_skid_fifo.sv
// ----------------------------------------------------------------------------
// ifu_skid_fifo
// Two-entry FIFO of fetch_entry_t that absorbs words already in flight from
// the instruction memory while decode is stalled. The head is a register, so
// nothing downstream sees a combinational path from push_entry_i.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   push_i        : write push_entry_i this cycle
//   push_entry_i  : entry to write
//   pop_i         : drop the head entry (ignored when empty)
//   flush_i       : discard all entries; dominates push and pop
//   head_o        : oldest entry (registered)
//   count_o       : number of valid entries (0..2)
// ----------------------------------------------------------------------------
module ifu_skid_fifo
    import ifu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o
);

    fetch_entry_t head_q, head_d;
    fetch_entry_t tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         pop_ok;
    logic [1:0]   kept;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pop_ok  = pop_i & (count_q != 2'd0);
        kept    = count_q - {1'b0, pop_ok};
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            // Popping a full FIFO shifts the second entry into the head slot.
            if (pop_ok && count_q == 2'd2) begin
                head_d = tail_q;
            end
            // The new entry lands in the first slot left free after the pop.
            if (push_i) begin
                if (kept == 2'd0) begin
                    head_d = push_entry_i;
                end else if (kept == 2'd1) begin
                    tail_d = push_entry_i;
                end
            end
            count_d = kept + {1'b0, push_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= ENTRY_RESET;
            tail_q  <= ENTRY_RESET;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
// Owns the PC, drives the word address of a registered-read instruction
// memory and delivers {instruction, pc} to decode as a valid/ready stream.
// Build option: define IFU_HALT_DETECT_EN to stop fetching after a HALT_WORD
// has been pushed; without it the HALTED state is unreachable and halted=0.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   imem_addr       : word address to memory (the pc register)
//   imem_data       : memory data for the address of the previous cycle
//   redirect_valid  : load redirect_pc and flush everything younger
//   redirect_pc     : redirect target
//   dec_valid/ready : decode stream; a transfer happens on a cycle where
//                     dec_valid & dec_ready are both 1. While dec_valid=1 and
//                     dec_ready=0, dec_inst/dec_pc hold; dec_valid only drops
//                     without a transfer when a redirect flushes the buffer.
//   dec_inst/dec_pc : head of the fetch buffer
//   halted          : fetch stopped on HALT_WORD
// ----------------------------------------------------------------------------
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                ADDR_W    = IFU_ADDR_W,
    parameter int                DATA_W    = IFU_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [DATA_W-1:0] dec_inst,
    output logic [ADDR_W-1:0] dec_pc,
    output logic              halted
);

    ifu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

    logic              pop;
    logic              push;
    logic              issue;
    logic [2:0]        occ_next;
    logic [1:0]        count;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    assign pop = dec_valid & dec_ready;

    // Entries the buffer must still hold after this cycle, counting the word
    // already in flight. Issuing only when this is <= 1 keeps room for the
    // word issued now, so the 2-entry buffer cannot overflow.
    assign occ_next = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue    = (state_q == RUN) & ~redirect_valid & (occ_next <= 3'd1);

    // A word issued in the same cycle a halt word was pushed returns while
    // HALTED and is dropped, so nothing past the halt reaches decode.
    assign push = inflight_q & ~redirect_valid & (state_q != HALTED);

    always_comb begin
        push_entry      = ENTRY_RESET;
        push_entry.inst = imem_data;
        push_entry.pc   = inflight_pc_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                state_d = RUN;
`ifdef IFU_HALT_DETECT_EN
                if (push && imem_data == HALT_WORD) begin
                    state_d = HALTED;
                end
`endif
            end
`ifdef IFU_HALT_DETECT_EN
            HALTED: state_d = HALTED;
`endif
            default: state_d = BOOT;
        endcase
        if (redirect_valid) begin
            state_d = RUN;
        end
    end

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d          = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    ifu_skid_fifo u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop & ~redirect_valid),
        .flush_i      (redirect_valid),
        .head_o       (head),
        .count_o      (count)
    );

    assign imem_addr = pc_q;
    assign dec_valid = (count != 2'd0);
    assign dec_inst  = head.inst;
    assign dec_pc    = head.pc;

`ifdef IFU_HALT_DETECT_EN
    assign halted = (state_q == HALTED);
`else
    logic unused_halt_word;
    assign unused_halt_word = ^HALT_WORD;
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
    import ifu_pkg::*;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_data;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          dec_valid;
    logic          dec_ready = 1'b0;
    logic [DW-1:0] dec_inst;
    logic [AW-1:0] dec_pc;
    logic          halted;

    int errors = 0;
    int checks = 0;
    int pops   = 0;

    // Instruction memory model: registered read, one cycle after the address.
    logic [DW-1:0] mem [64];
    always @(posedge clk) imem_data <= mem[imem_addr];

    // Scoreboard state: expected pc sequence of delivered words.
    logic [AW-1:0] exp_q[$];
    logic          mon_en = 1'b0;
    int            since_flush = 3;
    logic          hold_pend = 1'b0;
    logic [AW-1:0] hold_pc;
    logic [DW-1:0] hold_inst;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc),
        .halted         (halted)
    );

    // Leaves the bench just after the edge that starts cycle 0.
    task automatic do_reset();
        mon_en         = 1'b0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(AW'(0));
        hold_pend   = 1'b0;
        since_flush = 3;
        mon_en      = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    // Delivered words must follow the pc sequence started by reset or the
    // latest redirect, each carrying mem[pc]; stalled outputs must hold; no
    // valid in the two cycles after a redirect.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            logic [AW-1:0] front;
            logic [AW-1:0] nxt;
            if (since_flush < 3) since_flush++;
            if (since_flush == 1 || since_flush == 2) begin
                checks++;
                if (dec_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_gap: dec_valid=%b required 0 (%0d cycles after redirect)", dec_valid, since_flush);
                end
            end
            if (hold_pend) begin
                checks++;
                if (dec_valid !== 1'b1 || dec_pc !== hold_pc || dec_inst !== hold_inst) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b pc=%0d inst=%h required valid=1 pc=%0d inst=%h",
                             dec_valid, dec_pc, dec_inst, hold_pc, hold_inst);
                end
            end
            hold_pend = 1'b0;
            if (redirect_valid === 1'b1) begin
                exp_q.delete();
                exp_q.push_back(redirect_pc);
                since_flush = 0;
            end else if (dec_valid === 1'b1 && dec_ready === 1'b1) begin
                if (exp_q.size() < 4) begin
                    nxt = exp_q[$] + AW'(1);
                    exp_q.push_back(nxt);
                end
                front = exp_q.pop_front();
                pops++;
                checks++;
                if (dec_pc !== front || dec_inst !== mem[front]) begin
                    errors++;
                    $display("FAIL stream: got pc=%0d inst=%h required pc=%0d inst=%h",
                             dec_pc, dec_inst, front, mem[front]);
                end
            end else if (dec_valid === 1'b1) begin
                hold_pend = 1'b1;
                hold_pc   = dec_pc;
                hold_inst = dec_inst;
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 64; i++) mem[i] = DW'(i);
        dec_ready = 1'b1;
        rst       = 1'b1;
        mon_en    = 1'b0;
        tick();
        checks++;
        if (dec_valid !== 1'b0 || dec_inst !== NOP_WORD || dec_pc !== AW'(0) || halted !== 1'b0 || imem_addr !== AW'(0)) begin
            errors++;
            $display("FAIL reset_values: got valid=%b inst=%h pc=%0d halted=%b addr=%0d required 0 %h 0 0 0",
                     dec_valid, dec_inst, dec_pc, halted, imem_addr, NOP_WORD);
        end
    endtask

    task automatic test_boot();
        do_reset();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (dec_valid !== (k >= 3)) begin
                errors++;
                $display("FAIL boot_valid: cycle %0d got %b required %b", k, dec_valid, (k >= 3));
            end
            if (k == 1) begin
                checks++;
                if (imem_addr !== AW'(0)) begin
                    errors++;
                    $display("FAIL boot_addr: got %0d required 0", imem_addr);
                end
            end
            if (k >= 3) begin
                checks++;
                if (dec_pc !== AW'(k - 3) || dec_inst !== DW'(k - 3)) begin
                    errors++;
                    $display("FAIL boot_stream: cycle %0d got pc=%0d inst=%h required %0d", k, dec_pc, dec_inst, k - 3);
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int k = 0; k < 25; k++) begin
            dec_ready = !(k >= 6 && k <= 10);
            @(negedge clk);
            if (k >= 6 && k <= 10) begin
                checks++;
                if (dec_valid !== 1'b1 || dec_pc !== AW'(3) || imem_addr !== AW'(5)) begin
                    errors++;
                    $display("FAIL stall_freeze: cycle %0d got valid=%b pc=%0d addr=%0d required 1 3 5",
                             k, dec_valid, dec_pc, imem_addr);
                end
            end
            tick();
        end
        dec_ready = 1'b1;
    endtask

    task automatic test_redirect();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            dec_ready      = (k < 6 || k >= 9);
            redirect_valid = (k == 8);
            redirect_pc    = AW'(32);
            @(negedge clk);
            if (k == 9 || k == 10) begin
                checks++;
                if (dec_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL redirect_gap: cycle %0d got valid=%b required 0", k, dec_valid);
                end
            end
            if (k == 11) begin
                checks++;
                if (dec_valid !== 1'b1 || dec_pc !== AW'(32) || dec_inst !== DW'(32)) begin
                    errors++;
                    $display("FAIL redirect_target: got valid=%b pc=%0d inst=%h required 1 32 20", dec_valid, dec_pc, dec_inst);
                end
            end
            tick();
        end
        redirect_valid = 1'b0;
        dec_ready      = 1'b1;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 15; k++) begin
            redirect_valid = (k == 6);
            redirect_pc    = AW'(62);
            @(negedge clk);
            if (k >= 9 && k <= 12) begin
                checks++;
                if (dec_valid !== 1'b1 || dec_pc !== AW'(62 + k - 9)) begin
                    errors++;
                    $display("FAIL wrap: cycle %0d got valid=%b pc=%0d required 1 %0d", k, dec_valid, dec_pc, (62 + k - 9) % 64);
                end
            end
            tick();
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (6) tick();
        #2;
        mon_en = 1'b0;
        checks++;
        if (dec_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: got valid=%b required 1", dec_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (dec_valid !== 1'b0 || dec_pc !== AW'(0) || dec_inst !== NOP_WORD || imem_addr !== AW'(0)) begin
            errors++;
            $display("FAIL midreset_async: got valid=%b pc=%0d inst=%h addr=%0d required 0 0 %h 0",
                     dec_valid, dec_pc, dec_inst, imem_addr, NOP_WORD);
        end
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (dec_valid !== (k >= 3) || (k >= 3 && dec_pc !== AW'(k - 3))) begin
                errors++;
                $display("FAIL midreset_restart: cycle %0d got valid=%b pc=%0d required %b %0d", k, dec_valid, dec_pc, (k >= 3), k - 3);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            if (mem[i] == DEFAULT_HALT_WORD) mem[i] = '0;
        end
        do_reset();
        pops = 0;
        for (int k = 0; k < 800; k++) begin
            dec_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = AW'($urandom_range(0, 63));
            @(negedge clk);
            checks++;
            if (halted !== 1'b0) begin
                errors++;
                $display("FAIL random_halted: cycle %0d got %b required 0", k, halted);
            end
            tick();
        end
        redirect_valid = 1'b0;
        dec_ready      = 1'b1;
        checks++;
        if (pops < 150) begin
            errors++;
            $display("FAIL random_progress: got %0d transfers required at least 150", pops);
        end
    endtask

`ifdef IFU_HALT_DETECT_EN
    task automatic test_halt();
        for (int i = 0; i < 64; i++) mem[i] = DW'(i);
        mem[5] = DEFAULT_HALT_WORD;
        do_reset();
        for (int k = 0; k < 26; k++) begin
            redirect_valid = (k == 20);
            redirect_pc    = AW'(0);
            @(negedge clk);
            if (k == 8) begin
                checks++;
                if (dec_valid !== 1'b1 || dec_pc !== AW'(5) || dec_inst !== DEFAULT_HALT_WORD || halted !== 1'b1) begin
                    errors++;
                    $display("FAIL halt_word: got valid=%b pc=%0d inst=%h halted=%b required 1 5 ffffffff 1",
                             dec_valid, dec_pc, dec_inst, halted);
                end
            end
            if (k >= 9 && k <= 20) begin
                checks++;
                if (dec_valid !== 1'b0 || halted !== 1'b1) begin
                    errors++;
                    $display("FAIL halt_hold: cycle %0d got valid=%b halted=%b required 0 1", k, dec_valid, halted);
                end
            end
            if (k == 21) begin
                checks++;
                if (halted !== 1'b0) begin
                    errors++;
                    $display("FAIL halt_release: got halted=%b required 0", halted);
                end
            end
            if (k == 23) begin
                checks++;
                if (dec_valid !== 1'b1 || dec_pc !== AW'(0)) begin
                    errors++;
                    $display("FAIL halt_resume: got valid=%b pc=%0d required 1 0", dec_valid, dec_pc);
                end
            end
            tick();
        end
        redirect_valid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_boot();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_mid();
`ifdef IFU_HALT_DETECT_EN
        test_halt();
`endif
        test_random();
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
